// File: rtl/qkv_line_serializer.sv
// qkv_line_serializer
// Unpacks full spike lines (2*SYSTOLIC_UNIT_NUM neurons x TIME_STEPS bits)
// into one TIME_STEPS-bit spike word per handshake. Up to two lines are
// buffered. The last neuron of each line and the end of each frame are flagged.
//
// Ports
//   s_clk               clock
//   s_rst               asynchronous, active-high reset
//   i_spikesLine_data   packed line; neuron k at [(k+1)*TS-1 : k*TS]
//   i_spikesLine_valid  line valid
//   o_spikesLine_ready  line buffer has a free slot (registered occupancy only)
//   o_spikes_out        current neuron's spike word (0 when empty)
//   o_spikes_valid      o_spikes_out valid
//   i_spikes_ready      downstream accepts the current word
//   o_spikes_last       current word is the last neuron of its line
//   o_frame_done        one-cycle pulse after the last word of a frame is taken
module qkv_line_serializer #(
    parameter int unsigned TIME_STEPS        = 4,
    parameter int unsigned SYSTOLIC_UNIT_NUM = 16,
    parameter int unsigned LINES_PER_FRAME   = 8
) (
    input  logic                                          s_clk,
    input  logic                                          s_rst,
    input  logic [2*SYSTOLIC_UNIT_NUM*TIME_STEPS-1:0]     i_spikesLine_data,
    input  logic                                          i_spikesLine_valid,
    output logic                                          o_spikesLine_ready,
    output logic [TIME_STEPS-1:0]                         o_spikes_out,
    output logic                                          o_spikes_valid,
    input  logic                                          i_spikes_ready,
    output logic                                          o_spikes_last,
    output logic                                          o_frame_done
);

    localparam int unsigned NEURONS = 2 * SYSTOLIC_UNIT_NUM;
    localparam int unsigned LINE_W  = NEURONS * TIME_STEPS;
    localparam int unsigned CNT_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int unsigned LC_W    = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    localparam logic [CNT_W-1:0] LAST_NEURON = CNT_W'(NEURONS - 1);
    localparam logic [LC_W-1:0]  LAST_LINE   = LC_W'(LINES_PER_FRAME - 1);

    // Line storage and bookkeeping
    logic [LINE_W-1:0]      r_buf [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic [CNT_W-1:0]       r_cnt;
    logic [LC_W-1:0]        r_line_cnt;
    logic                   r_frame_done;

    // Next-state values
    logic                   w_wr_ptr_nxt;
    logic                   w_rd_ptr_nxt;
    logic [1:0]             w_count_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [LC_W-1:0]        w_line_cnt_nxt;
    logic                   w_frame_done_nxt;

    // Handshake qualifiers
    logic                   w_line_ready;
    logic                   w_valid;
    logic                   w_last;
    logic                   w_wr;
    logic                   w_pop;
    logic                   w_free;

    // Head-line word view
    logic [LINE_W-1:0]      w_head;
    logic [TIME_STEPS-1:0]  w_words [NEURONS];
    logic [TIME_STEPS-1:0]  w_word;

    // Readiness is a function of the registered occupancy only, so a slot
    // freed this cycle is offered upstream one cycle later.
    assign w_line_ready = (r_count < 2'd2);
    assign w_valid      = (r_count != 2'd0);
    assign w_last       = w_valid && (r_cnt == LAST_NEURON);
    assign w_wr         = i_spikesLine_valid && w_line_ready;
    assign w_pop        = w_valid && i_spikes_ready;
    assign w_free       = w_pop && w_last;

    // Slice the head line into neuron words, then pick the current one
    assign w_head = r_buf[r_rd_ptr];

    for (genvar k = 0; k < NEURONS; k++) begin : g_words
        assign w_words[k] = w_head[k*TIME_STEPS +: TIME_STEPS];
    end

    assign w_word = w_words[r_cnt];

    // Outputs decode from registered state only, so they hold across stalls
    assign o_spikesLine_ready = w_line_ready;
    assign o_spikes_valid     = w_valid;
    assign o_spikes_out       = w_valid ? w_word : '0;
    assign o_spikes_last      = w_last;
    assign o_frame_done       = r_frame_done;

    // Line storage; contents need no reset since occupancy gates every read
    always_ff @(posedge s_clk) begin
        if (w_wr) begin
            r_buf[r_wr_ptr] <= i_spikesLine_data;
        end
    end

    // Next-state for pointers, occupancy, neuron and line counters
    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_count_nxt      = r_count;
        w_cnt_nxt        = r_cnt;
        w_line_cnt_nxt   = r_line_cnt;
        w_frame_done_nxt = 1'b0;

        if (w_wr) begin
            w_wr_ptr_nxt = ~r_wr_ptr;
        end

        if (w_pop) begin
            if (w_last) begin
                w_cnt_nxt    = '0;
                w_rd_ptr_nxt = ~r_rd_ptr;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        // A write and a line free in the same cycle leave occupancy unchanged
        case ({w_wr, w_free})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase

        if (w_free) begin
            if (r_line_cnt == LAST_LINE) begin
                w_line_cnt_nxt   = '0;
                w_frame_done_nxt = 1'b1;
            end else begin
                w_line_cnt_nxt = r_line_cnt + LC_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_cnt        <= '0;
            r_line_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_count      <= w_count_nxt;
            r_cnt        <= w_cnt_nxt;
            r_line_cnt   <= w_line_cnt_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

endmodule
